// File: rtl/awgn_pkg.sv
// Shared constants and helpers for the AWGN channel: sigma table, LFSR taps,
// Irwin-Hall centring and SNR clamping.
package awgn_pkg;

   localparam logic [31:0]     LFSR_MASK = 32'h8020_0003;
   localparam logic [9:0]      IH_MEAN   = 10'd510;
   // Index 0 (0 dB) sits in the least significant byte.
   localparam logic [9:0][7:0] SIGMA_LUT = {8'd64, 8'd72, 8'd81, 8'd90, 8'd102,
                                            8'd114, 8'd128, 8'd143, 8'd161, 8'd180};

   function automatic logic [3:0] snr_clamp(input logic [3:0] snr);
      if (snr > 4'd9) begin
         return 4'd9;
      end else begin
         return snr;
      end
   endfunction

   function automatic logic [7:0] sigma_of(input logic [3:0] snr);
      return SIGMA_LUT[snr_clamp(snr)];
   endfunction

   function automatic logic [9:0] byte_sum(input logic [31:0] s);
      return {2'b00, s[7:0]} + {2'b00, s[15:8]} + {2'b00, s[23:16]} + {2'b00, s[31:24]};
   endfunction

endpackage

// File: rtl/awgn_lfsr32.sv
// 32-bit right-shifting Galois LFSR; steps only when adv is high.
module awgn_lfsr32
   import awgn_pkg::*;
#(
   parameter logic [31:0] SEED = 32'h0000_0001
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        adv,
   output logic [31:0] state
);

   // An all-zero seed would lock the register, so it is replaced by 1.
   localparam logic [31:0] SEED_EFF = (SEED == 32'h0000_0000) ? 32'h0000_0001 : SEED;

   logic [31:0] state_r;

   // State register: reload on reset, step on each strobe
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= SEED_EFF;
      end else if (adv) begin
         if (state_r[0]) begin
            state_r <= (state_r >> 1) ^ LFSR_MASK;
         end else begin
            state_r <= state_r >> 1;
         end
      end
   end

   assign state = state_r;

endmodule

// File: rtl/awgn_channel_p.sv
// Complex AWGN channel: three-stage stallable pipeline adding scaled Irwin-Hall
// noise to I/Q samples, with saturation and an output handshake counter.
module awgn_channel_p
   import awgn_pkg::*;
#(
   parameter int          DATA_W = 24,
   parameter int          SHIFT  = 4,
   parameter int          CNT_W  = 20,
   parameter logic [31:0] SEED_I = 32'h0000_0001,
   parameter logic [31:0] SEED_Q = 32'hACE1_2345
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] x_re,
   input  logic signed [DATA_W-1:0] x_im,
   input  logic [3:0]               snr_sel,
   input  logic                     noise_en,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] y_re,
   output logic signed [DATA_W-1:0] y_im,
   output logic                     out_sat,
   output logic [CNT_W-1:0]         sample_cnt
);

   // Product width: 11-bit centred draw times 9-bit non-negative sigma.
   localparam int PW = 20;

   logic                     en_s;
   logic                     accept_s;
   logic [31:0]              lfsr_i_s;
   logic [31:0]              lfsr_q_s;
   logic signed [10:0]       ci_s;
   logic signed [10:0]       cq_s;

   logic                     a_valid_r;
   logic signed [DATA_W-1:0] a_re_r;
   logic signed [DATA_W-1:0] a_im_r;
   logic signed [10:0]       a_ci_r;
   logic signed [10:0]       a_cq_r;
   logic [7:0]               a_sig_r;

   logic signed [PW-1:0]     prod_i_s;
   logic signed [PW-1:0]     prod_q_s;

   logic                     b_valid_r;
   logic signed [DATA_W-1:0] b_re_r;
   logic signed [DATA_W-1:0] b_im_r;
   logic signed [PW-1:0]     b_ni_r;
   logic signed [PW-1:0]     b_nq_r;

   logic [DATA_W:0]          sum_re_s;
   logic [DATA_W:0]          sum_im_s;

   logic                     out_valid_r;
   logic                     out_sat_r;
   logic signed [DATA_W-1:0] y_re_r;
   logic signed [DATA_W-1:0] y_im_r;
   logic [CNT_W-1:0]         cnt_r;

   function automatic logic clipped(input logic [DATA_W:0] v);
      return v[DATA_W] ^ v[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] sat_val(input logic [DATA_W:0] v);
      if (v[DATA_W] != v[DATA_W-1]) begin
         return v[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      end else begin
         return v[DATA_W-1:0];
      end
   endfunction

   assign en_s     = out_ready | ~out_valid_r;
   assign in_ready = en_s & reset;
   assign accept_s = in_valid & in_ready;

   awgn_lfsr32 #(.SEED(SEED_I)) u_lfsr_i (
      .clk   (clk),
      .reset (reset),
      .adv   (accept_s),
      .state (lfsr_i_s)
   );

   awgn_lfsr32 #(.SEED(SEED_Q)) u_lfsr_q (
      .clk   (clk),
      .reset (reset),
      .adv   (accept_s),
      .state (lfsr_q_s)
   );

   // Centred Irwin-Hall draw per rail, zeroed in bypass
   always_comb begin
      ci_s = 11'sd0;
      cq_s = 11'sd0;
      if (noise_en) begin
         ci_s = $signed({1'b0, byte_sum(lfsr_i_s)}) - $signed({1'b0, IH_MEAN});
         cq_s = $signed({1'b0, byte_sum(lfsr_q_s)}) - $signed({1'b0, IH_MEAN});
      end else begin
         ci_s = 11'sd0;
         cq_s = 11'sd0;
      end
   end

   // Stage A: capture sample, draws and sigma on accept; bubble otherwise
   always_ff @(posedge clk) begin
      if (!reset) begin
         a_valid_r <= 1'b0;
         a_re_r    <= '0;
         a_im_r    <= '0;
         a_ci_r    <= 11'sd0;
         a_cq_r    <= 11'sd0;
         a_sig_r   <= 8'd0;
      end else if (en_s) begin
         a_valid_r <= accept_s;
         if (accept_s) begin
            a_re_r  <= x_re;
            a_im_r  <= x_im;
            a_ci_r  <= ci_s;
            a_cq_r  <= cq_s;
            a_sig_r <= sigma_of(snr_sel);
         end
      end
   end

   assign prod_i_s = $signed({{(PW-11){a_ci_r[10]}}, a_ci_r}) * $signed({{(PW-8){1'b0}}, a_sig_r});
   assign prod_q_s = $signed({{(PW-11){a_cq_r[10]}}, a_cq_r}) * $signed({{(PW-8){1'b0}}, a_sig_r});

   // Stage B: scale noise and floor-shift it
   always_ff @(posedge clk) begin
      if (!reset) begin
         b_valid_r <= 1'b0;
         b_re_r    <= '0;
         b_im_r    <= '0;
         b_ni_r    <= '0;
         b_nq_r    <= '0;
      end else if (en_s) begin
         b_valid_r <= a_valid_r;
         if (a_valid_r) begin
            b_re_r <= a_re_r;
            b_im_r <= a_im_r;
            b_ni_r <= prod_i_s >>> SHIFT;
            b_nq_r <= prod_q_s >>> SHIFT;
         end
      end
   end

   // One guard bit above DATA_W makes the add exact before clipping.
   assign sum_re_s = {b_re_r[DATA_W-1], b_re_r} + {{(DATA_W+1-PW){b_ni_r[PW-1]}}, b_ni_r};
   assign sum_im_s = {b_im_r[DATA_W-1], b_im_r} + {{(DATA_W+1-PW){b_nq_r[PW-1]}}, b_nq_r};

   // Stage C: saturated output register, frozen while stalled
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid_r <= 1'b0;
         out_sat_r   <= 1'b0;
         y_re_r      <= '0;
         y_im_r      <= '0;
      end else if (en_s) begin
         out_valid_r <= b_valid_r;
         if (b_valid_r) begin
            y_re_r    <= sat_val(sum_re_s);
            y_im_r    <= sat_val(sum_im_s);
            out_sat_r <= clipped(sum_re_s) | clipped(sum_im_s);
         end
      end
   end

   // Completed output handshake counter, wraps naturally
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_r <= '0;
      end else if (out_valid_r & out_ready) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   assign out_valid  = out_valid_r;
   assign out_sat    = out_sat_r;
   assign y_re       = y_re_r;
   assign y_im       = y_im_r;
   assign sample_cnt = cnt_r;

endmodule

// File: tb/tb_awgn_channel_p.sv
// Self-checking bench for awgn_channel_p: directed vector table, hand-written
// corner sequences and randomized traffic against an arithmetic reference model.
module tb_awgn_channel_p;

   localparam int DW   = 24;
   localparam int CW   = 20;
   localparam int MAXV = 8388607;
   localparam int MINV = -8388608;
   localparam int unsigned SEED_I = 32'h0000_0001;
   localparam int unsigned SEED_Q = 32'hACE1_2345;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] x_re;
   logic signed [DW-1:0] x_im;
   logic [3:0]           snr_sel;
   logic                 noise_en;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [DW-1:0] y_re;
   logic signed [DW-1:0] y_im;
   logic                 out_sat;
   logic [CW-1:0]        sample_cnt;

   always #5 clk = ~clk;

   awgn_channel_p dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .x_re       (x_re),
      .x_im       (x_im),
      .snr_sel    (snr_sel),
      .noise_en   (noise_en),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .y_re       (y_re),
      .y_im       (y_im),
      .out_sat    (out_sat),
      .sample_cnt (sample_cnt)
   );

   typedef struct { int re; int im; bit sat; int cyc; } exp_t;
   typedef struct { int snr; bit en; int xr; int xi; int er; int ei; bit es; } vec_t;

   exp_t        q[$];
   vec_t        vt[9];
   int          sigtab[10] = '{180, 161, 143, 128, 114, 102, 90, 81, 72, 64};
   int unsigned li, lq;
   int          cur_re, cur_im, cur_snr;
   bit          cur_en;
   int          checks, errors, cyc, exp_cnt;
   bit          lat_chk, got_out, got, prev_hold, prev_sat, cap_sat;
   int          cap_re, cap_im, prev_re, prev_im, nsat, nstat;
   real         s_re, ss_re, s_im, ss_im, mean, sd;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int unsigned lfsr_next(input int unsigned s);
      return (s & 32'd1) != 0 ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   // noise = floor((sum of bytes - 510) * sigma / 16)
   function automatic int model_noise(input int unsigned s, input int snr);
      int sum, k, p;
      sum = int'(s & 32'hFF) + int'((s >> 8) & 32'hFF) + int'((s >> 16) & 32'hFF) + int'((s >> 24) & 32'hFF);
      k = (snr > 9) ? 9 : snr;
      p = (sum - 510) * sigtab[k];
      if (p >= 0) return p / 16;
      else        return -((-p + 15) / 16);
   endfunction

   function automatic int rnd24();
      int v;
      v = int'($urandom);
      return v >>> 8;
   endfunction

   task automatic drive(input bit v, input int re, input int im, input int snr, input bit en);
      in_valid = v;
      cur_re = re;   x_re = DW'(re);
      cur_im = im;   x_im = DW'(im);
      cur_snr = snr; snr_sel = 4'(snr);
      cur_en = en;   noise_en = en;
   endtask

   // One clock: check at the falling edge, update the model, return #1 after the rising edge.
   task automatic step();
      exp_t   e;
      longint sr, si;
      bit     cr, ci;
      @(negedge clk);
      cyc++;
      got_out = 1'b0;
      chk("in_ready", in_ready, (reset && (out_ready || !out_valid)) ? 1 : 0);
      chk("sample_cnt", sample_cnt, exp_cnt);
      if (prev_hold) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_y_re", y_re, prev_re);
         chk("hold_y_im", y_im, prev_im);
         chk("hold_sat", out_sat, prev_sat);
      end
      if (reset) begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("spurious_output", 1, 0);
            end else begin
               e = q.pop_front();
               chk("y_re", y_re, e.re);
               chk("y_im", y_im, e.im);
               chk("out_sat", out_sat, e.sat);
               if (lat_chk) chk("latency", cyc - e.cyc, 3);
            end
            got_out = 1'b1;
            cap_re = y_re; cap_im = y_im; cap_sat = out_sat;
            exp_cnt = (exp_cnt + 1) % (1 << CW);
         end
         if (in_valid && in_ready) begin
            sr = longint'(cur_re) + (cur_en ? model_noise(li, cur_snr) : 0);
            si = longint'(cur_im) + (cur_en ? model_noise(lq, cur_snr) : 0);
            cr = (sr > MAXV) || (sr < MINV);
            ci = (si > MAXV) || (si < MINV);
            e.re  = (sr > MAXV) ? MAXV : (sr < MINV) ? MINV : int'(sr);
            e.im  = (si > MAXV) ? MAXV : (si < MINV) ? MINV : int'(si);
            e.sat = cr | ci;
            e.cyc = cyc;
            q.push_back(e);
            li = lfsr_next(li);
            lq = lfsr_next(lq);
         end
      end else begin
         q.delete();
         exp_cnt = 0;
         li = SEED_I;
         lq = SEED_Q;
      end
      prev_hold = reset && out_valid && !out_ready;
      prev_re = y_re; prev_im = y_im; prev_sat = out_sat;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      in_valid = 1'b0;
      step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_y_re", y_re, 0);
      chk("rst_y_im", y_im, 0);
      chk("rst_out_sat", out_sat, 0);
      chk("rst_sample_cnt", sample_cnt, 0);
      reset = 1'b1;
   endtask

   task automatic drain(input int n);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < n; k++) step();
      chk("drain_empty", q.size(), 0);
   endtask

   task automatic expect_first(input int idx, input string tag);
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         step();
         if (got_out) begin
            got = 1'b1;
            chk({tag, "_re"}, cap_re, vt[idx].er);
            chk({tag, "_im"}, cap_im, vt[idx].ei);
            chk({tag, "_sat"}, cap_sat, vt[idx].es);
         end
      end
      if (!got) chk({tag, "_timeout"}, 0, 1);
   endtask

   initial begin
      vt[0] = '{8,  1'b1, 0, 0, -2291, -41, 1'b0};
      vt[1] = '{0,  1'b1, 0, 0, -5727, -102, 1'b0};
      vt[2] = '{9,  1'b1, 0, 0, -2036, -36, 1'b0};
      vt[3] = '{15, 1'b1, 0, 0, -2036, -36, 1'b0};
      vt[4] = '{0,  1'b1, -8388608, 8388607, -8388608, 8388505, 1'b1};
      vt[5] = '{0,  1'b1, -8382881, 100, -8388608, -2, 1'b0};
      vt[6] = '{3,  1'b1, 8388607, -8388608, 8384535, -8388608, 1'b1};
      vt[7] = '{5,  1'b1, 1000, -1000, -2245, -1058, 1'b0};
      vt[8] = '{8,  1'b0, 1234, -4321, 1234, -4321, 1'b0};

      checks = 0; errors = 0; cyc = 0; exp_cnt = 0; prev_hold = 1'b0;
      li = SEED_I; lq = SEED_Q;
      reset = 1'b0; out_ready = 1'b1;
      drive(1'b0, 0, 0, 0, 1'b1);
      @(posedge clk);
      #1;

      // Directed table: each vector is the first sample after reset.
      for (int i = 0; i < 9; i++) begin
         do_reset();
         lat_chk = 1'b1;
         out_ready = 1'b1;
         drive(1'b1, vt[i].xr, vt[i].xi, vt[i].snr, vt[i].en);
         step();
         in_valid = 1'b0;
         expect_first(i, "vec");
         chk("vec_cnt", sample_cnt, 1);
      end

      // Bypass: 100 back-to-back samples pass through unchanged.
      do_reset();
      lat_chk = 1'b1;
      for (int i = 0; i < 100; i++) begin
         drive(1'b1, 1000, -1000, int'($urandom_range(0, 15)), 1'b0);
         step();
         if (got_out) begin
            chk("bypass_re", cap_re, 1000);
            chk("bypass_im", cap_im, -1000);
         end
      end
      drain(6);
      chk("bypass_cnt", sample_cnt, 100);

      // Saturation at both rails at 0 dB.
      do_reset();
      nsat = 0;
      for (int i = 0; i < 1000; i++) begin
         drive(1'b1, MAXV, MINV, 0, 1'b1);
         step();
         if (got_out && cap_sat) nsat++;
      end
      drain(6);
      chk("sat_seen", (nsat > 0) ? 1 : 0, 1);

      // Backpressure: out_ready low for 10 cycles under continuous input.
      do_reset();
      lat_chk = 1'b0;
      for (int i = 0; i < 60; i++) begin
         out_ready = !(i >= 20 && i < 30);
         drive(1'b1, rnd24(), rnd24(), int'($urandom_range(0, 15)), 1'b1);
         step();
      end
      drain(8);

      // Reset mid-stream with samples in flight.
      do_reset();
      lat_chk = 1'b1;
      for (int i = 0; i < 50; i++) begin
         drive(1'b1, rnd24(), rnd24(), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         step();
      end
      reset = 1'b0;
      step();
      reset = 1'b1;
      in_valid = 1'b0;
      chk("mid_out_valid", out_valid, 0);
      chk("mid_cnt", sample_cnt, 0);
      drive(1'b1, vt[0].xr, vt[0].xi, vt[0].snr, vt[0].en);
      step();
      in_valid = 1'b0;
      expect_first(0, "post_reset");

      // Randomized traffic with random stalls and bubbles.
      do_reset();
      lat_chk = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         out_ready = ($urandom_range(0, 2) != 0);
         drive(($urandom_range(0, 3) != 0), rnd24(), rnd24(),
               int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
         step();
      end
      drain(8);

      // Noise statistics at 0 dB on a zero input.
      do_reset();
      lat_chk = 1'b1;
      s_re = 0.0; ss_re = 0.0; s_im = 0.0; ss_im = 0.0; nstat = 0;
      for (int i = 0; i < 65536 + 6; i++) begin
         drive((i < 65536), 0, 0, 0, 1'b1);
         step();
         if (got_out) begin
            nstat++;
            s_re += real'(cap_re); ss_re += real'(cap_re) * real'(cap_re);
            s_im += real'(cap_im); ss_im += real'(cap_im) * real'(cap_im);
         end
      end
      chk("stat_count", nstat, 65536);
      mean = s_re / 65536.0;
      sd = $sqrt(ss_re / 65536.0 - mean * mean);
      chk("stat_mean_re", (mean > -50.0 && mean < 50.0) ? 1 : 0, 1);
      chk("stat_std_re", (sd > 0.95 * 1663.0 && sd < 1.05 * 1663.0) ? 1 : 0, 1);
      mean = s_im / 65536.0;
      sd = $sqrt(ss_im / 65536.0 - mean * mean);
      chk("stat_mean_im", (mean > -50.0 && mean < 50.0) ? 1 : 0, 1);
      chk("stat_std_im", (sd > 0.95 * 1663.0 && sd < 1.05 * 1663.0) ? 1 : 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/awgn_channel_p.md
# awgn_channel_p

Parametrised complex AWGN channel: adds pseudo-random Gaussian-approximate noise to a stream of signed I/Q samples at a runtime-selectable SNR (0–9 dB). Noise is the centred sum of four uniform bytes (Irwin-Hall, N=4) from independent 32-bit LFSRs per rail, scaled by a sigma LUT. The block has valid/ready handshaking on both sides, a 3-stage stallable pipeline, saturation, a noise bypass and a sample counter. It sits between the modulator/symbol source and the demodulator in the link test chain.

## Interface
- DATA_W, 24, signed I/Q sample width
- SHIFT, 4, arithmetic right shift applied to the scaled noise
- CNT_W, 20, output sample counter width
- SEED_I, 32'h0000_0001, I-rail LFSR seed; value 0 is replaced by 1
- SEED_Q, 32'hACE1_2345, Q-rail LFSR seed; value 0 is replaced by 1
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts the sample this cycle
- x_re, x_im  in  DATA_W  signed input sample
- snr_sel  in  4  SNR in dB, sampled with each accepted sample; values >9 treated as 9
- noise_en  in  1  0 = noise forced to zero, sampled with each sample
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts
- y_re, y_im  out  DATA_W  signed noisy sample
- out_sat  out  1  either rail of this output clipped
- sample_cnt  out  CNT_W  count of completed output handshakes, wraps to 0

## Operation
- LFSR: Galois, right shift, poly x^32+x^22+x^2+x+1 (mask 32'h8020_0003): if lsb, next = (s>>1)^mask, else s>>1. Advances once per accepted input, never otherwise; advances even when noise_en=0.
- Stage A (on accept): s = sum of the four bytes of the current LFSR state (0..1020); c = s − 510, signed 11 bit; c forced 0 if noise_en=0; sigma from LUT; register x, c, sigma.
- Sigma LUT, 8-bit unsigned, index dB 0..9: 180,161,143,128,114,102,90,81,72,64.
- Stage B: p = c × sigma, signed 19 bit (|p| ≤ 91800); n = p >>> SHIFT (arithmetic, floor).
- Stage C: y = x + n at DATA_W+1 bits, saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1]; out_sat = 1 if either rail clipped.
- sample_cnt increments on out_valid & out_ready.

## Timing
- Pipeline enable en = out_ready | ~out_valid; all stages advance together when en=1. in_ready = en while reset is high; 0 while reset is low.
- Latency: an input accepted at edge k appears with out_valid=1 after edge k+3 when unstalled; full throughput, 1 sample/cycle.
- Stall: y_re, y_im, out_sat, out_valid held stable while out_valid & ~out_ready; no sample dropped or duplicated.
- Bubbles propagate as invalid stages; LFSR does not move on bubbles.
- Reset (synchronous, low): out_valid 0, y_re/y_im 0, out_sat 0, sample_cnt 0, all stage valids 0, LFSRs reload seeds. Reset mid-stream discards in-flight samples; the first post-reset sample reproduces the first-ever noise value.
- snr_sel/noise_en changes take effect per sample, no glitch to in-flight samples.

## Structure
- Package awgn_pkg: sigma LUT constant, LFSR mask constant, Irwin-Hall mean (510), SNR index clamp function.
- Sub-module awgn_lfsr32 (seed parameter, advance strobe, 32-bit state out), instantiated twice.
- Top holds the three pipeline stages, handshake, saturation and counter.

## Test plan
- Known value: reset, SEED defaults, snr_sel=8, noise_en=1, x=0+j0, out_ready=1 -> after 3 cycles y_re=−2291, y_im=−41, out_sat=0, sample_cnt=1.
- Bypass: noise_en=0, x=1000−j1000, 100 consecutive samples -> outputs equal inputs, 3-cycle latency, sample_cnt=100.
- Saturation: x_re=8388607, x_im=−8388608, snr_sel=0, 1000 samples -> y never wraps; out_sat=1 exactly when the model noise on a clipped rail pushes past the limit.
- Backpressure: continuous in_valid, out_ready low 10 cycles mid-stream -> outputs held, in_ready low while full, output sequence equals reference model with no loss/duplication.
- Reset mid-stream: 50 samples, reset low 1 cycle with 3 in flight -> out_valid 0, sample_cnt 0; next sample under first test's stimulus gives −2291/−41.
- Statistics: 65536 samples x=0, snr_sel=0 -> noise mean |μ| < 50, std within 5 % of 1663.
